and_gate_unit: RTL and testbench

- Parameterised bitwise-AND datapath stage: y = a & b across WIDTH bits (default 20).
- Provides an unregistered combinational result and a 1-cycle registered result with valid qualifier.
- Registered result carries status flags: zero, all-ones, population count.
- Sits in the ALU/logic-op path wherever a masked operand must be pipelined.

---
 rtl/and_gate_pkg.sv | 12 +
 rtl/and_popcount.sv | 28 ++
 rtl/and_gate_unit.sv | 80 ++++++++
 tb/tb_and_gate_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared definitions for the bitwise-AND datapath stage.
package and_gate_pkg;

    // Default operand/result width of the AND stage.
    localparam int DEFAULT_WIDTH = 20;

    // Width needed to hold a population count in the range 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : and_gate_pkg

// File: rtl/and_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module and_popcount
    import and_gate_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] w_sum;

    // Sum every bit of the vector; CNT_W covers 0..WIDTH so no overflow.
    always_comb begin
        w_sum = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                w_sum = w_sum + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                w_sum = w_sum;
            end
        end
    end

    assign cnt = w_sum;

endmodule : and_popcount

// File: rtl/and_gate_unit.sv
// Bitwise-AND stage: combinational result plus a 1-cycle registered
// result with valid qualifier and zero / all-ones / popcount flags.
module and_gate_unit
    import and_gate_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y,
    output logic             valid_out,
    output logic             y_zero,
    output logic             y_all_ones,
    output logic [CNT_W-1:0] y_popcnt
);

    logic [WIDTH-1:0] w_and;
    logic             w_zero;
    logic             w_all_ones;
    logic [CNT_W-1:0] w_popcnt;

    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic             r_zero;
    logic             r_all_ones;
    logic [CNT_W-1:0] r_popcnt;

    // The AND itself and the flag reductions, all derived from one value
    // so the registered flags can never disagree with the registered y.
    always_comb begin
        w_and      = a & b;
        w_zero     = ~(|w_and);
        w_all_ones = &w_and;
    end

    and_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .vec (w_and),
        .cnt (w_popcnt)
    );

    // Result bank: captures on valid_in, holds otherwise; valid_out is a
    // one-cycle echo of valid_in. Reset state is y=0 with matching flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y        <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_zero     <= 1'b1;
            r_all_ones <= 1'b0;
            r_popcnt   <= {CNT_W{1'b0}};
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_y        <= w_and;
                r_zero     <= w_zero;
                r_all_ones <= w_all_ones;
                r_popcnt   <= w_popcnt;
            end else begin
                r_y        <= r_y;
                r_zero     <= r_zero;
                r_all_ones <= r_all_ones;
                r_popcnt   <= r_popcnt;
            end
        end
    end

    assign y_comb     = w_and;
    assign y          = r_y;
    assign valid_out  = r_valid;
    assign y_zero     = r_zero;
    assign y_all_ones = r_all_ones;
    assign y_popcnt   = r_popcnt;

endmodule : and_gate_unit

// File: tb/tb_and_gate_unit.sv
// Directed self-checking bench for and_gate_unit (WIDTH = 20).
module tb_and_gate_unit;

    localparam int WIDTH = 20;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] y;
    logic             valid_out;
    logic             y_zero;
    logic             y_all_ones;
    logic [CNT_W-1:0] y_popcnt;

    int tests_run;
    int tests_failed;

    and_gate_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .a          (a),
        .b          (b),
        .y_comb     (y_comb),
        .y          (y),
        .valid_out  (valid_out),
        .y_zero     (y_zero),
        .y_all_ones (y_all_ones),
        .y_popcnt   (y_popcnt)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs, checked together after a capture edge.
    task automatic check_reg(input string tag, input logic [19:0] ey, input logic ev,
                             input logic ez, input logic eo, input logic [4:0] ep);
        check({tag, ".y"},          64'(y),          64'(ey));
        check({tag, ".valid_out"},  64'(valid_out),  64'(ev));
        check({tag, ".y_zero"},     64'(y_zero),     64'(ez));
        check({tag, ".y_all_ones"}, 64'(y_all_ones), 64'(eo));
        check({tag, ".y_popcnt"},   64'(y_popcnt),   64'(ep));
    endtask

    // One clock: launch on current inputs, sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held with all-ones operands.
        rst_n    = 1'b0;
        valid_in = 1'b1;
        a        = 20'hFFFFF;
        b        = 20'hFFFFF;
        step();
        step();
        check_reg("reset", 20'h00000, 1'b0, 1'b1, 1'b0, 5'd0);
        check("reset.y_comb", 64'(y_comb), 64'h00000_FFFFF);

        // Release and capture alternating bits.
        rst_n = 1'b1;
        a     = 20'hAAAAA;
        b     = 20'h55555;
        #1;
        check("alt.y_comb", 64'(y_comb), 64'h0);
        step();
        check_reg("alt", 20'h00000, 1'b1, 1'b1, 1'b0, 5'd0);

        // All ones.
        a = 20'hFFFFF;
        b = 20'hFFFFF;
        step();
        check_reg("ones", 20'hFFFFF, 1'b1, 1'b0, 1'b1, 5'd20);

        // Zero mask.
        a = 20'h00000;
        b = 20'hFFFFF;
        step();
        check_reg("zmask", 20'h00000, 1'b1, 1'b1, 1'b0, 5'd0);

        // Idle cycle with all-ones operands: result holds, valid drops.
        valid_in = 1'b0;
        a        = 20'hFFFFF;
        b        = 20'hFFFFF;
        step();
        check_reg("hold", 20'h00000, 1'b0, 1'b1, 1'b0, 5'd0);
        check("hold.y_comb", 64'(y_comb), 64'h00000_FFFFF);

        // Unknown operands while idle must not disturb the result.
        a = 'x;
        b = 'x;
        step();
        check_reg("xhold", 20'h00000, 1'b0, 1'b1, 1'b0, 5'd0);

        // Partial mask, then back-to-back captures.
        valid_in = 1'b1;
        a        = 20'hF0F0F;
        b        = 20'hFF00F;
        step();
        check_reg("part", 20'hF000F, 1'b1, 1'b0, 1'b0, 5'd8);
        a = 20'h12345;
        b = 20'h0F0F0;
        step();
        check_reg("b2b1", 20'h02040, 1'b1, 1'b0, 1'b0, 5'd2);
        a = 20'hFFFFF;
        b = 20'h80001;
        step();
        check_reg("b2b2", 20'h80001, 1'b1, 1'b0, 1'b0, 5'd2);

        // Asynchronous reset between edges while valid_out is high.
        #2 rst_n = 1'b0;
        #1;
        check_reg("midrst", 20'h00000, 1'b0, 1'b1, 1'b0, 5'd0);
        a = 20'h0F0F0;
        b = 20'hFFFFF;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reg("resume", 20'h0F0F0, 1'b1, 1'b0, 1'b0, 5'd8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_and_gate_unit
